// File: rtl/rob.sv
// Reorder buffer for the R10K-style core. Dispatch allocates at the tail, entries are
// marked done out of order, and the oldest completed entry retires once per cycle,
// handing Told to the free list and T to the architectural map.
module rob #(
   parameter int ROB_SIZE = 32,
   parameter int PREG_W   = 6,
   parameter int AREG_W   = 5,
   parameter int IDX_W    = $clog2(ROB_SIZE)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dispatch_valid,
   input  logic [AREG_W-1:0] dispatch_dest_areg,
   input  logic              dispatch_has_dest,
   input  logic [PREG_W-1:0] dispatch_T,
   input  logic [PREG_W-1:0] dispatch_Told,
   output logic              dispatch_ready,
   output logic [IDX_W-1:0]  dispatch_rob_idx,
   input  logic              complete_valid,
   input  logic [IDX_W-1:0]  complete_rob_idx,
   input  logic              squash,
   output logic              retire_valid,
   output logic              retire_has_dest,
   output logic [AREG_W-1:0] retire_dest_areg,
   output logic [PREG_W-1:0] retire_T,
   output logic [PREG_W-1:0] retire_Told,
   output logic [IDX_W-1:0]  retire_rob_idx,
   output logic [IDX_W:0]    count,
   output logic              empty
);

   localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(ROB_SIZE);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [IDX_W-1:0]    head_q, head_d;
   logic [IDX_W-1:0]    tail_q, tail_d;
   logic [IDX_W:0]      count_q, count_d;
   logic [ROB_SIZE-1:0] valid_q, valid_d;
   logic [ROB_SIZE-1:0] complete_q, complete_d;
   logic [ROB_SIZE-1:0] has_dest_q, has_dest_d;
   logic [AREG_W-1:0]   areg_q [ROB_SIZE];
   logic [AREG_W-1:0]   areg_d [ROB_SIZE];
   logic [PREG_W-1:0]   t_q    [ROB_SIZE];
   logic [PREG_W-1:0]   t_d    [ROB_SIZE];
   logic [PREG_W-1:0]   told_q [ROB_SIZE];
   logic [PREG_W-1:0]   told_d [ROB_SIZE];

   logic dispatch_fire;
   logic complete_fire;
   logic retire_fire;

   // Handshake qualifiers; readiness looks only at registered count so a
   // same-cycle retire never lets a full buffer accept.
   always_comb begin
      dispatch_ready = (count_q != FULL_CNT);
      dispatch_fire  = dispatch_valid & dispatch_ready & ~squash;
      complete_fire  = complete_valid & ~squash & valid_q[complete_rob_idx];
      retire_fire    = valid_q[head_q] & complete_q[head_q] & ~squash;
   end

   // Retire port and status outputs; payload is zeroed when nothing retires.
   always_comb begin
      dispatch_rob_idx = tail_q;
      count            = count_q;
      empty            = (count_q == '0);
      retire_valid     = retire_fire;
      retire_rob_idx   = retire_fire ? head_q : '0;
      retire_has_dest  = retire_fire & has_dest_q[head_q];
      retire_dest_areg = retire_fire ? areg_q[head_q] : '0;
      retire_T         = retire_fire ? t_q[head_q]    : '0;
      retire_Told      = retire_fire ? told_q[head_q] : '0;
   end

   // Next-state for pointers, occupancy and per-entry flags. Completion is applied
   // before the retire clear so a late completion of the retiring head cannot revive it.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      valid_d    = valid_q;
      complete_d = complete_q;

      if (complete_fire) complete_d[complete_rob_idx] = 1'b1;

      if (retire_fire) begin
         valid_d[head_q]    = 1'b0;
         complete_d[head_q] = 1'b0;
         head_d             = head_q + IDX_ONE;
      end

      if (dispatch_fire) begin
         valid_d[tail_q]    = 1'b1;
         complete_d[tail_q] = 1'b0;
         tail_d             = tail_q + IDX_ONE;
      end

      case ({dispatch_fire, retire_fire})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (squash) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         valid_d    = '0;
         complete_d = '0;
      end
   end

   // Next-state for the entry payload, written only at allocation.
   always_comb begin
      has_dest_d = has_dest_q;
      areg_d     = areg_q;
      t_d        = t_q;
      told_d     = told_q;
      if (dispatch_fire) begin
         has_dest_d[tail_q] = dispatch_has_dest;
         areg_d[tail_q]     = dispatch_dest_areg;
         t_d[tail_q]        = dispatch_T;
         told_d[tail_q]     = dispatch_Told;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         complete_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         complete_q <= complete_d;
      end
   end

   // Payload storage; never read unless the matching valid bit is set, so no reset.
   always_ff @(posedge clock) begin
      has_dest_q <= has_dest_d;
      areg_q     <= areg_d;
      t_q        <= t_d;
      told_q     <= told_d;
   end

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: allocation, out-of-order completion,
// in-order retire, full/ready boundary, index wrap, steady state and squash.
module tb_rob;

   localparam int ROB_SIZE = 32;
   localparam int PREG_W   = 6;
   localparam int AREG_W   = 5;
   localparam int IDX_W    = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              dispatch_valid;
   logic [AREG_W-1:0] dispatch_dest_areg;
   logic              dispatch_has_dest;
   logic [PREG_W-1:0] dispatch_T;
   logic [PREG_W-1:0] dispatch_Told;
   logic              dispatch_ready;
   logic [IDX_W-1:0]  dispatch_rob_idx;
   logic              complete_valid;
   logic [IDX_W-1:0]  complete_rob_idx;
   logic              squash;
   logic              retire_valid;
   logic              retire_has_dest;
   logic [AREG_W-1:0] retire_dest_areg;
   logic [PREG_W-1:0] retire_T;
   logic [PREG_W-1:0] retire_Told;
   logic [IDX_W-1:0]  retire_rob_idx;
   logic [IDX_W:0]    count;
   logic              empty;

   int checks = 0;
   int errors = 0;

   rob #(.ROB_SIZE(ROB_SIZE), .PREG_W(PREG_W), .AREG_W(AREG_W), .IDX_W(IDX_W)) dut (
      .clock(clock), .reset(reset),
      .dispatch_valid(dispatch_valid), .dispatch_dest_areg(dispatch_dest_areg),
      .dispatch_has_dest(dispatch_has_dest), .dispatch_T(dispatch_T),
      .dispatch_Told(dispatch_Told), .dispatch_ready(dispatch_ready),
      .dispatch_rob_idx(dispatch_rob_idx), .complete_valid(complete_valid),
      .complete_rob_idx(complete_rob_idx), .squash(squash),
      .retire_valid(retire_valid), .retire_has_dest(retire_has_dest),
      .retire_dest_areg(retire_dest_areg), .retire_T(retire_T),
      .retire_Told(retire_Told), .retire_rob_idx(retire_rob_idx),
      .count(count), .empty(empty)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      dispatch_valid     = 1'b0;
      dispatch_dest_areg = '0;
      dispatch_has_dest  = 1'b0;
      dispatch_T         = '0;
      dispatch_Told      = '0;
      complete_valid     = 1'b0;
      complete_rob_idx   = '0;
      squash             = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic set_disp(input logic [AREG_W-1:0] a, input logic [PREG_W-1:0] t,
                           input logic [PREG_W-1:0] told);
      dispatch_valid     = 1'b1;
      dispatch_dest_areg = a;
      dispatch_has_dest  = 1'b1;
      dispatch_T         = t;
      dispatch_Told      = told;
   endtask

   task automatic set_comp(input logic [IDX_W-1:0] idx);
      complete_valid   = 1'b1;
      complete_rob_idx = idx;
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_ready", dispatch_ready, 1);
      chk("rst_idx", dispatch_rob_idx, 0);
      chk("rst_rv", retire_valid, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_T", retire_T, 0);
      chk("rst_Told", retire_Told, 0);
      chk("rst_areg", retire_dest_areg, 0);
      chk("rst_hd", retire_has_dest, 0);
      chk("rst_ridx", retire_rob_idx, 0);

      // single instruction round trip
      set_disp(5'd3, 6'd40, 6'd3);
      chk("t1_didx", dispatch_rob_idx, 0);
      cyc();
      idle();
      chk("t1_count", count, 1);
      chk("t1_rv0", retire_valid, 0);
      set_comp(5'd0);
      cyc();
      idle();
      chk("t1_rv1", retire_valid, 1);
      chk("t1_T", retire_T, 40);
      chk("t1_Told", retire_Told, 3);
      chk("t1_areg", retire_dest_areg, 3);
      chk("t1_hd", retire_has_dest, 1);
      chk("t1_ridx", retire_rob_idx, 0);
      cyc();
      chk("t1_empty", empty, 1);
      chk("t1_rv2", retire_valid, 0);
      chk("t1_count0", count, 0);

      // out-of-order completion, in-order retire
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_disp(5'(i + 1), 6'(10 + i), 6'(20 + i));
         chk("t2_didx", dispatch_rob_idx, 32'(i));
         cyc();
      end
      idle();
      set_comp(5'd2);
      cyc();
      idle();
      chk("t2_hold2", retire_valid, 0);
      set_comp(5'd0);
      cyc();
      idle();
      chk("t2_rv0", retire_valid, 1);
      chk("t2_ridx0", retire_rob_idx, 0);
      chk("t2_T0", retire_T, 10);
      cyc();
      chk("t2_hold1", retire_valid, 0);
      chk("t2_cnt2", count, 2);
      set_comp(5'd1);
      cyc();
      idle();
      chk("t2_rv1", retire_valid, 1);
      chk("t2_ridx1", retire_rob_idx, 1);
      chk("t2_T1", retire_T, 11);
      cyc();
      chk("t2_rv2", retire_valid, 1);
      chk("t2_ridx2", retire_rob_idx, 2);
      chk("t2_Told2", retire_Told, 22);
      chk("t2_cnt1", count, 1);
      cyc();
      chk("t2_cnt0", count, 0);
      chk("t2_empty", empty, 1);

      // fill to capacity, refused extra dispatch, ready lags retire
      do_reset();
      for (int i = 0; i < ROB_SIZE; i++) begin
         set_disp(5'(i), 6'(i), 6'(i + 1));
         cyc();
      end
      chk("t3_full_cnt", count, 32);
      chk("t3_full_rdy", dispatch_ready, 0);
      chk("t3_full_tail", dispatch_rob_idx, 0);
      set_disp(5'd9, 6'd63, 6'd62);
      cyc();
      chk("t3_33_cnt", count, 32);
      chk("t3_33_tail", dispatch_rob_idx, 0);
      set_comp(5'd0);
      cyc();
      complete_valid = 1'b0;
      chk("t3_ret_rv", retire_valid, 1);
      chk("t3_ret_rdy", dispatch_ready, 0);
      cyc();
      chk("t3_after_rdy", dispatch_ready, 1);
      chk("t3_after_cnt", count, 31);
      chk("t3_after_tail", dispatch_rob_idx, 0);
      chk("t3_after_rv", retire_valid, 0);
      cyc();
      idle();
      chk("t3_refill_cnt", count, 32);
      chk("t3_refill_tail", dispatch_rob_idx, 1);

      // wrap-around from head=tail=30
      do_reset();
      for (int i = 0; i < 30; i++) begin
         set_disp(5'd1, 6'd1, 6'd2);
         cyc();
      end
      idle();
      for (int k = 0; k < 30; k++) begin
         set_comp(5'(k));
         cyc();
      end
      idle();
      cyc();
      chk("t4_drained", count, 0);
      chk("t4_head_tail", dispatch_rob_idx, 30);
      for (int i = 0; i < 4; i++) begin
         set_disp(5'(i + 4), 6'(50 + i), 6'(i));
         chk("t4_didx", dispatch_rob_idx, 32'((30 + i) % 32));
         cyc();
      end
      idle();
      set_comp(5'd1);
      cyc();
      chk("t4_hold_a", retire_valid, 0);
      set_comp(5'd0);
      cyc();
      chk("t4_hold_b", retire_valid, 0);
      set_comp(5'd31);
      cyc();
      chk("t4_hold_c", retire_valid, 0);
      set_comp(5'd30);
      cyc();
      idle();
      chk("t4_rv30", retire_valid, 1);
      chk("t4_ridx30", retire_rob_idx, 30);
      chk("t4_T30", retire_T, 50);
      cyc();
      chk("t4_ridx31", retire_rob_idx, 31);
      chk("t4_T31", retire_T, 51);
      cyc();
      chk("t4_ridx0", retire_rob_idx, 0);
      chk("t4_T0", retire_T, 52);
      cyc();
      chk("t4_ridx1", retire_rob_idx, 1);
      chk("t4_T1", retire_T, 53);
      chk("t4_areg1", retire_dest_areg, 7);
      cyc();
      chk("t4_empty", empty, 1);

      // steady state: dispatch and retire together
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_disp(5'd2, 6'(60 + i), 6'd0);
         cyc();
      end
      idle();
      set_comp(5'd0);
      cyc();
      chk("t5_rv", retire_valid, 1);
      chk("t5_cnt5", count, 5);
      set_disp(5'd2, 6'd33, 6'd0);
      set_comp(5'd1);
      cyc();
      idle();
      chk("t5_cnt_same", count, 5);
      chk("t5_tail", dispatch_rob_idx, 6);
      chk("t5_head", retire_rob_idx, 1);
      chk("t5_T1", retire_T, 61);

      // squash overrides everything in the same cycle
      do_reset();
      for (int i = 0; i < 7; i++) begin
         set_disp(5'd4, 6'(i), 6'd0);
         cyc();
      end
      idle();
      set_comp(5'd0);
      cyc();
      idle();
      chk("t6_pre_rv", retire_valid, 1);
      chk("t6_pre_cnt", count, 7);
      squash = 1'b1;
      set_disp(5'd4, 6'd44, 6'd0);
      set_comp(5'd1);
      #1;
      chk("t6_sq_rv", retire_valid, 0);
      chk("t6_sq_T", retire_T, 0);
      cyc();
      idle();
      chk("t6_cnt", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_tail", dispatch_rob_idx, 0);
      chk("t6_rv", retire_valid, 0);
      set_comp(5'd0);
      cyc();
      idle();
      chk("t6_ignored_comp", retire_valid, 0);
      chk("t6_cnt_still", count, 0);
      cyc();
      chk("t6_rv_later", retire_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer directly downstream of dispatch in the R10K-style out-of-order core.
- Each cycle, dispatch may allocate one entry holding the destination architectural register, the new physical tag T and the previous tag Told.
- Execute/complete logic marks entries done in any order.
- The block retires the oldest completed entry once per cycle, in program order, and hands Told to the free list and T to the architectural map.

Parameters:
- ROB_SIZE, 32, number of entries; must be a power of 2, at least 4.
- PREG_W, 6, physical register tag width.
- AREG_W, 5, architectural register index width.
- IDX_W, $clog2(ROB_SIZE), ROB index width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- dispatch_valid  input  1  dispatch presents an instruction for allocation.
- dispatch_dest_areg  input  AREG_W  destination architectural register.
- dispatch_has_dest  input  1  instruction writes a register.
- dispatch_T  input  PREG_W  newly allocated physical tag.
- dispatch_Told  input  PREG_W  previous mapping of the destination register.
- dispatch_ready  output  1  ROB can accept this cycle.
- dispatch_rob_idx  output  IDX_W  index the dispatching instruction receives (current tail).
- complete_valid  input  1  an executed instruction reports done.
- complete_rob_idx  input  IDX_W  entry being completed.
- squash  input  1  flush all entries (mispredict/exception recovery).
- retire_valid  output  1  head entry retires this cycle.
- retire_has_dest  output  1  head has a destination.
- retire_dest_areg  output  AREG_W  head destination register.
- retire_T  output  PREG_W  head new tag.
- retire_Told  output  PREG_W  head old tag, to be freed.
- retire_rob_idx  output  IDX_W  head index.
- count  output  IDX_W+1  number of occupied entries.
- empty  output  1  count==0.

Behaviour:
- State: per entry valid, complete, has_dest, dest_areg, T, Told; head, tail (IDX_W, wrap modulo ROB_SIZE); count.
- Reset (synchronous, highest priority): head=tail=0, count=0, all valid=0, all complete=0.
  - Resulting outputs: dispatch_ready=1, dispatch_rob_idx=0, retire_valid=0, empty=1, count=0; all retire_* payload outputs are 0.
- dispatch_ready = (count != ROB_SIZE). It depends only on registered count, never on same-cycle retire. When full with a simultaneous retire, dispatch is still refused.
- Dispatch fire = dispatch_valid & dispatch_ready & ~squash.
  - At the posedge, the entry at tail is written with valid=1, complete=0 and the payload; tail advances by 1.
  - dispatch_valid while not ready is ignored; dispatch holds the instruction.
- Completion (complete_valid & ~squash) at the posedge sets complete=1 on entry complete_rob_idx if valid=1; it is ignored if the entry is invalid.
  - Completing an already-complete entry is harmless.
- Retire is combinational from registered state: retire_valid = valid[head] & complete[head] & ~squash.
  - retire_* payload = entry[head], zero when retire_valid=0.
  - At the posedge with retire_valid=1: valid[head]=0, complete[head]=0, head advances by 1.
- Retire rate is at most 1 per cycle. A completion arriving for the head is visible on retire_valid the following cycle (1-cycle complete-to-retire latency).
- Count update: +1 on dispatch fire only, -1 on retire only, unchanged on both or neither.
  - A simultaneous dispatch and retire while empty cannot occur, since retire needs a valid head.
- Squash: at the posedge, head=tail=0, count=0, all valid/complete cleared. Squash overrides dispatch, complete and retire issued in the same cycle; retire_valid is forced to 0 that cycle.
- Wrap-around: the index after ROB_SIZE-1 is 0. Full/empty are determined by count, never by head==tail.
- dispatch_rob_idx = tail, always driven, including when not ready.

Test Plan:
- Reset, then dispatch 1 instr (areg 3, T=40, Told=3) -> dispatch_rob_idx=0, count=1, retire_valid=0. Complete idx 0 -> next cycle retire_valid=1 with T=40, Told=3; the following cycle empty=1.
- Dispatch 3 (idx 0,1,2), complete idx 2 then idx 0:
  - retire idx 0 only; idx 2 is held.
  - Complete idx 1 -> idx 1 and idx 2 retire on consecutive cycles, count reaches 0.
- Dispatch 32 with no completes -> count=32, dispatch_ready=0. A 33rd dispatch_valid is not accepted and tail stays 0.
  - Complete idx 0: retire cycle still shows dispatch_ready=0; the next cycle shows ready=1.
- Wrap: with head=tail=30, dispatch 4 -> indices 30,31,0,1. Complete all in reverse order -> retire order 30,31,0,1.
- Steady state with count=5: dispatch and retire in the same cycle -> count stays 5, head and tail both advance.
- With count=7 and head complete, assert squash together with dispatch_valid and complete_valid -> retire_valid=0 that cycle; next cycle count=0, empty=1, dispatch_rob_idx=0, no entry retires afterwards.
